// File: rtl/writeback_commit_pkg.sv
// Shared encodings for the writeback/commit stage: CR field bits and commit FSM states.
package writeback_commit_pkg;

  // CR field bit encodings, field layout {LT, GT, EQ, SO}
  localparam logic [3:0] CR_LT = 4'b1000;
  localparam logic [3:0] CR_GT = 4'b0100;
  localparam logic [3:0] CR_EQ = 4'b0010;
  localparam logic [3:0] CR_SO = 4'b0001;

  localparam int unsigned XLen        = 32;
  localparam int unsigned NumRegs     = 32;
  localparam int unsigned NumCrFields = 8;

  typedef enum logic [1:0] {
    WbBoot,
    WbIdle,
    WbNext,
    WbHalt
  } wb_state_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two asynchronous read ports, one synchronous write port and synchronous reset.
module regfile_2r1w #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 32,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr1,
  input  logic [AddrW-1:0] raddr2,
  output logic [Width-1:0] rdata1,
  output logic [Width-1:0] rdata2
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_q <= '{default: '0};
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // No write-to-read bypass: the core never reads across a commit edge.
  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/writeback_commit.sv
// Commit stage: writes GPR/FPR/CR, resolves branches, updates PC/LR and restarts fetch.
module writeback_commit
  import writeback_commit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        writeback_en,
  input  logic [31:0] dout,
  input  logic [31:0] f_dout,
  input  logic [3:0]  cr_wdata,
  input  logic        gpr_we,
  input  logic        fpr_we,
  input  logic        cr_we,
  input  logic [4:0]  rd,
  input  logic [2:0]  cr_idx,
  input  logic        is_branch,
  input  logic        br_uncond,
  input  logic [3:0]  br_mask,
  input  logic        br_sense,
  input  logic [31:0] br_target,
  input  logic        lr_we,
  input  logic        lr_from_dout,
  input  logic        halt,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  fs1,
  input  logic [4:0]  fs2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] fdata1,
  output logic [31:0] fdata2,
  output logic [3:0]  cr_field,
  output logic [31:0] lr,
  output logic [31:0] pc,
  output logic        fetch_en,
  output logic        halted
);

  wb_state_e   state_q, state_d;
  logic [31:0] pc_q, lr_q;
  logic [3:0]  cr_q [NumCrFields];
  logic        fetch_en_q, fetch_en_d;

  logic        commit;
  logic        taken;
  logic [31:0] pc_seq;

  // Commits outside IDLE are protocol errors and are dropped.
  assign commit = writeback_en && (state_q == WbIdle);
  assign pc_seq = pc_q + 32'(PC_STEP);
  // Branch sees the pre-commit CR value even if the same commit writes it.
  assign taken  = is_branch && (br_uncond || ((|(cr_q[cr_idx] & br_mask)) == br_sense));

  always_comb begin
    state_d    = state_q;
    fetch_en_d = 1'b0;
    unique case (state_q)
      WbBoot: begin
        state_d    = WbIdle;
        fetch_en_d = 1'b1;
      end
      WbIdle: begin
        if (writeback_en) begin
          state_d    = halt ? WbHalt : WbNext;
          fetch_en_d = !halt;
        end
      end
      WbNext:  state_d = WbIdle;
      WbHalt:  state_d = WbHalt;
      default: state_d = WbBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= WbBoot;
      fetch_en_q <= 1'b0;
      pc_q       <= RESET_PC;
      lr_q       <= '0;
      cr_q       <= '{default: '0};
    end else begin
      state_q    <= state_d;
      fetch_en_q <= fetch_en_d;
      if (commit) begin
        pc_q <= taken ? br_target : pc_seq;
        if (lr_we) begin
          lr_q <= lr_from_dout ? dout : pc_seq;
        end
        if (cr_we) begin
          cr_q[cr_idx] <= cr_wdata;
        end
      end
    end
  end

  regfile_2r1w #(
    .Width (XLen),
    .Depth (NumRegs)
  ) u_gpr (
    .clk    (clk),
    .rstn   (rstn),
    .we     (commit && gpr_we),
    .waddr  (rd),
    .wdata  (dout),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  regfile_2r1w #(
    .Width (XLen),
    .Depth (NumRegs)
  ) u_fpr (
    .clk    (clk),
    .rstn   (rstn),
    .we     (commit && fpr_we),
    .waddr  (rd),
    .wdata  (f_dout),
    .raddr1 (fs1),
    .raddr2 (fs2),
    .rdata1 (fdata1),
    .rdata2 (fdata2)
  );

  assign cr_field = cr_q[cr_idx];
  assign lr       = lr_q;
  assign pc       = pc_q;
  assign fetch_en = fetch_en_q;
  assign halted   = (state_q == WbHalt);

  // Stray pulses after halt are tolerated silently; the core has already stopped.
  wb_protocol_a : assert property (@(posedge clk) disable iff (!rstn)
    writeback_en |-> (state_q inside {WbIdle, WbHalt}));

endmodule
